// File: rtl/pt_top_level.sv
// pt_top_level: user-FPGA top level for the proFPGA duo test design (site TA1).
// Exposes a four-entry register file to the host over the 20-bit DMBI link
// and drives the three module LEDs.
//
// Parameters:
//   DEVICE     FPGA type string; "XV7S" sets bit 0 of the ID register.
// Ports:
//   CLK_P_0/CLK_N_0    master clock 0 (differential); rising CLK_P_0 is the only edge used
//   SYNC_P_0/SYNC_N_0  master sync 0 (differential); SYNC_P_0 high = synchronous reset
//   DMBI_H2F[19:0]     command  {req, we, addr[1:0], wdata[15:0]}
//   DMBI_F2H[19:0]     response {ack, err, addr[1:0], rdata[15:0]}, all zero when no ack
//   LED_BLUE/GREEN/RED active-high LEDs
// Register map: 0 ID (RO), 1 SCRATCH (RW), 2 LED_CTRL (RW, [3]=override enable,
//   [2:0]={blue,green,red}), 3 CMD_CNT (RO, accepted commands).
// Configuration macro:
//   PT_HEARTBEAT_EN    defined: LED_GREEN is bit 23 of a free-running heartbeat counter;
//                      undefined: LED_GREEN shows "out of reset".
module pt_top_level #(
  parameter DEVICE = "XV7S"
) (
  input  logic        CLK_P_0,
  input  logic        CLK_N_0,
  input  logic        SYNC_P_0,
  input  logic        SYNC_N_0,
  input  logic [19:0] DMBI_H2F,
  output logic [19:0] DMBI_F2H,
  output logic        LED_BLUE,
  output logic        LED_GREEN,
  output logic        LED_RED
);

  localparam logic [15:0] ID_VALUE = {15'h6850, (DEVICE == "XV7S")};

  // Only the positive legs of the differential pairs are used.
  logic unused_diff;
  assign unused_diff = CLK_N_0 ^ SYNC_N_0;

  logic        rst;
  logic        req;
  logic        we;
  logic [1:0]  addr;
  logic [15:0] wdata;

  assign rst   = SYNC_P_0;
  assign req   = DMBI_H2F[19];
  assign we    = DMBI_H2F[18];
  assign addr  = DMBI_H2F[17:16];
  assign wdata = DMBI_H2F[15:0];

  logic [15:0] scratch_q;
  logic [3:0]  led_ctrl_q;
  logic [15:0] cmd_cnt_q;
  logic        sticky_q;

`ifdef PT_HEARTBEAT_EN
`ifdef SYNTHESIS
  localparam logic [23:0] HB_STEP = 24'h000001;
`else
  // Fast heartbeat in simulation: bit 23 toggles every 8 cycles.
  localparam logic [23:0] HB_STEP = 24'h100000;
`endif
  logic [23:0] hb_cnt_q;
  logic        green_idle;
  assign green_idle = hb_cnt_q[23];
`else
  logic        green_idle;
  assign green_idle = 1'b1;
`endif

  logic [15:0] cur_rdata;
  logic [15:0] resp_rdata;
  logic        wr_rw;
  logic        wr_ro;
  logic [19:0] f2h_d;

  always_comb begin
    cur_rdata  = '0;
    resp_rdata = '0;
    wr_rw      = 1'b0;
    wr_ro      = 1'b0;
    f2h_d      = '0;

    unique case (addr)
      2'd0:    cur_rdata = ID_VALUE;
      2'd1:    cur_rdata = scratch_q;
      2'd2:    cur_rdata = {12'h000, led_ctrl_q};
      default: cur_rdata = cmd_cnt_q;
    endcase

    wr_rw = req && we && (addr == 2'd1 || addr == 2'd2);
    wr_ro = req && we && (addr == 2'd0 || addr == 2'd3);

    // A successful write echoes the value as it will be stored.
    if (wr_rw)
      resp_rdata = (addr == 2'd1) ? wdata : {12'h000, wdata[3:0]};
    else
      resp_rdata = cur_rdata;

    if (req)
      f2h_d = {1'b1, wr_ro, addr, resp_rdata};
  end

  always_ff @(posedge CLK_P_0) begin
    if (rst) begin
      scratch_q  <= '0;
      led_ctrl_q <= '0;
      cmd_cnt_q  <= '0;
      sticky_q   <= 1'b0;
      DMBI_F2H   <= '0;
      LED_RED    <= 1'b1;
      LED_BLUE   <= 1'b0;
      LED_GREEN  <= 1'b0;
`ifdef PT_HEARTBEAT_EN
      hb_cnt_q   <= '0;
`endif
    end else begin
      DMBI_F2H <= f2h_d;

      if (req)
        cmd_cnt_q <= cmd_cnt_q + 16'd1;

      if (wr_rw && addr == 2'd1)
        scratch_q <= wdata;

      // Clearing (LED_CTRL write) and setting (RO write) are mutually
      // exclusive because only one command is accepted per cycle.
      if (wr_rw && addr == 2'd2) begin
        led_ctrl_q <= wdata[3:0];
        sticky_q   <= 1'b0;
      end else if (wr_ro) begin
        sticky_q   <= 1'b1;
      end

      // LEDs follow register state with one cycle of lag.
      if (led_ctrl_q[3]) begin
        LED_BLUE  <= led_ctrl_q[2];
        LED_GREEN <= led_ctrl_q[1];
        LED_RED   <= led_ctrl_q[0];
      end else begin
        LED_BLUE  <= sticky_q;
        LED_GREEN <= green_idle;
        LED_RED   <= 1'b0;
      end

`ifdef PT_HEARTBEAT_EN
      hb_cnt_q <= hb_cnt_q + HB_STEP;
`endif
    end
  end

endmodule

// File: tb/tb_pt_top_level.sv
// tb_pt_top_level: self-checking bench for pt_top_level. Directed test-plan
// sequences plus randomized commands with sporadic resets, all compared
// against a register-map model of the host-visible behaviour.
module tb_pt_top_level;

  logic        CLK_P_0 = 1'b0;
  logic        CLK_N_0;
  logic        SYNC_P_0 = 1'b1;
  logic        SYNC_N_0;
  logic [19:0] DMBI_H2F = '0;
  logic [19:0] DMBI_F2H;
  logic        LED_BLUE;
  logic        LED_GREEN;
  logic        LED_RED;

  always #5 CLK_P_0 = ~CLK_P_0;
  assign CLK_N_0  = ~CLK_P_0;
  assign SYNC_N_0 = ~SYNC_P_0;

  pt_top_level #(.DEVICE("XV7S")) dut (
    .CLK_P_0   (CLK_P_0),
    .CLK_N_0   (CLK_N_0),
    .SYNC_P_0  (SYNC_P_0),
    .SYNC_N_0  (SYNC_N_0),
    .DMBI_H2F  (DMBI_H2F),
    .DMBI_F2H  (DMBI_F2H),
    .LED_BLUE  (LED_BLUE),
    .LED_GREEN (LED_GREEN),
    .LED_RED   (LED_RED)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Model state: register file contents as plain integers.
  int unsigned m_scratch, m_led_ctrl, m_cnt, m_sticky, m_hb_n;
  int unsigned e_f2h, e_red, e_blue, e_green;

  // Expected outputs after an edge come from the state before the edge;
  // the command sampled at that edge then updates the state.
  function automatic void model_edge(input logic rst, input logic [19:0] h2f);
    int unsigned a, wd, cur, rd, err;
    if (rst) begin
      e_f2h = 0; e_red = 1; e_blue = 0; e_green = 0;
      m_scratch = 0; m_led_ctrl = 0; m_cnt = 0; m_sticky = 0; m_hb_n = 0;
      return;
    end
    if ((m_led_ctrl & 8) != 0) begin
      e_blue  = (m_led_ctrl >> 2) & 1;
      e_green = (m_led_ctrl >> 1) & 1;
      e_red   = m_led_ctrl & 1;
    end else begin
      e_blue  = m_sticky;
`ifdef PT_HEARTBEAT_EN
      e_green = (m_hb_n >> 3) & 1;
`else
      e_green = 1;
`endif
      e_red   = 0;
    end
    m_hb_n++;
    e_f2h = 0;
    if (h2f[19]) begin
      a  = h2f[17:16];
      wd = h2f[15:0];
      case (a)
        0: cur = 32'hD0A1;
        1: cur = m_scratch;
        2: cur = m_led_ctrl;
        default: cur = m_cnt;
      endcase
      err = 0;
      rd  = cur;
      if (h2f[18]) begin
        if (a == 1) begin
          m_scratch = wd; rd = wd;
        end else if (a == 2) begin
          m_led_ctrl = wd & 32'hF; rd = m_led_ctrl; m_sticky = 0;
        end else begin
          err = 1; m_sticky = 1;
        end
      end
      e_f2h = (1 << 19) | (err << 18) | (a << 16) | rd;
      m_cnt = (m_cnt + 1) % 65536;
    end
  endfunction

  task automatic step(input logic rst, input logic [19:0] h2f);
    SYNC_P_0 = rst;
    DMBI_H2F = h2f;
    @(posedge CLK_P_0);
    model_edge(rst, h2f);
    #1;
    check("f2h", DMBI_F2H, e_f2h);
    check("led_red", LED_RED, e_red);
    check("led_blue", LED_BLUE, e_blue);
    check("led_green", LED_GREEN, e_green);
  endtask

  initial begin
    // Reset held for 5 cycles.
    for (int i = 0; i < 5; i++) step(1'b1, 20'h80000);
    check("rst_f2h", DMBI_F2H, 20'h00000);
    check("rst_red", LED_RED, 1'b1);
    check("rst_blue", LED_BLUE, 1'b0);
    step(1'b0, 20'h00000);
    check("rel_red", LED_RED, 1'b0);

    // ID read, scratch write/read.
    step(1'b0, 20'h80000);
    check("id_read", DMBI_F2H, 20'h8D0A1);
    step(1'b0, 20'hD1234);
    check("scr_wr", DMBI_F2H, 20'h91234);
    step(1'b0, 20'h90000);
    check("scr_rd", DMBI_F2H, 20'h91234);

    // RO write error and clear via LED_CTRL write.
    step(1'b0, 20'hC5555);
    check("ro_wr", DMBI_F2H, 20'hCD0A1);
    step(1'b0, 20'h00000);
    check("sticky_on", LED_BLUE, 1'b1);
    step(1'b0, 20'hE0000);
    check("ledc_wr", DMBI_F2H, 20'hA0000);
    step(1'b0, 20'h00000);
    step(1'b0, 20'h00000);
    check("sticky_off", LED_BLUE, 1'b0);

    // Override: 0xD -> blue=1 green=0 red=1.
    step(1'b0, 20'hE000D);
    step(1'b0, 20'h00000);
    step(1'b0, 20'h00000);
    check("ovr_blue", LED_BLUE, 1'b1);
    check("ovr_green", LED_GREEN, 1'b0);
    check("ovr_red", LED_RED, 1'b1);
    // Six commands accepted since reset release.
    step(1'b0, 20'hB0000);
    check("cnt_rd", DMBI_F2H[15:0], 16'd6);

    // Back-to-back reads: ack every cycle.
    step(1'b0, 20'h80000);
    check("b2b_0", DMBI_F2H[19], 1'b1);
    step(1'b0, 20'h90000);
    check("b2b_1", DMBI_F2H[19], 1'b1);
    step(1'b0, 20'hA0000);
    check("b2b_2", DMBI_F2H[19], 1'b1);

    // Reset asserted together with a request: dropped.
    step(1'b1, 20'hB0000);
    check("rst_drop", DMBI_F2H, 20'h00000);
    step(1'b0, 20'hB0000);
    check("rst_cnt", DMBI_F2H, 20'hB0000);

    // Randomized traffic with sporadic resets.
    for (int i = 0; i < 800; i++) begin
      logic [19:0] h;
      h[19]    = ($urandom_range(0, 3) != 0);
      h[18]    = $urandom_range(0, 1);
      h[17:16] = $urandom_range(0, 3);
      h[15:0]  = $urandom_range(0, 65535);
      step($urandom_range(0, 49) == 0, h);
    end

    // Counter wrap: 65536 accepted commands bring CMD_CNT back to 0.
    step(1'b1, 20'h00000);
    for (int i = 0; i < 65535; i++) step(1'b0, 20'h90000);
    step(1'b0, 20'hB0000);
    check("cnt_max", DMBI_F2H[15:0], 16'hFFFF);
    step(1'b0, 20'hB0000);
    check("cnt_wrap", DMBI_F2H[15:0], 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
